// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry. Lookup is combinational on fetch_pc_i; training from
// the execute stage writes one entry at the clock edge.
//
// bpred_o packs the prediction bundle as
//   [PC_WIDTH+1] is_branch
//   [PC_WIDTH]   decision (1 = TAKEN, 0 = NOT_TAKEN)
//   [PC_WIDTH-1:0] pred_addr
module branch_predictor #(
    parameter int NUM_ENTRIES = 64,
    parameter int TAG_BITS    = 10,
    parameter int PC_WIDTH    = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [PC_WIDTH-1:0] fetch_pc_i,
    output logic [PC_WIDTH+1:0] bpred_o,
    input  logic                upd_valid_i,
    input  logic                stall_i,
    input  logic [PC_WIDTH-1:0] upd_pc_i,
    input  logic [1:0]          upd_kind_i,
    input  logic                upd_taken_i,
    input  logic [PC_WIDTH-1:0] upd_target_i,
    input  logic                upd_mispred_i,
    output logic [31:0]         mispred_cnt_o
);

    localparam int IDX_BITS = $clog2(NUM_ENTRIES);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_COND = 2'd1;
    localparam logic [1:0] KIND_JALR = 2'd2;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    // Saturating counter steps, range 0..3.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Table storage. Only valid is reset; tag/target/ctr are gated by it.
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]    tag_q    [NUM_ENTRIES];
    logic [PC_WIDTH-1:0]    target_q [NUM_ENTRIES];
    logic [1:0]             ctr_q    [NUM_ENTRIES];

    // Lookup side.
    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0] fetch_tag;
    logic                fetch_hit;
    logic                fetch_taken;
    logic [PC_WIDTH-1:0] fetch_seq;

    assign fetch_idx   = fetch_pc_i[IDX_BITS+1:2];
    assign fetch_tag   = fetch_pc_i[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign fetch_taken = fetch_hit && ctr_q[fetch_idx][1];
    assign fetch_seq   = fetch_pc_i + PC_WIDTH'(4);

    assign bpred_o = {fetch_hit,
                      fetch_taken ? TAKEN : NOT_TAKEN,
                      fetch_taken ? target_q[fetch_idx] : fetch_seq};

    // Training side.
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic                train_en;
    logic                unused_upd_pc;

    assign upd_idx       = upd_pc_i[IDX_BITS+1:2];
    assign upd_tag       = upd_pc_i[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign train_en      = upd_valid_i && !stall_i;
    // Byte-offset and upper PC bits do not take part in index/tag.
    assign unused_upd_pc = ^upd_pc_i;

    logic                wr_en;
    logic                wr_valid;
    logic [TAG_BITS-1:0] wr_tag;
    logic [PC_WIDTH-1:0] wr_target;
    logic [1:0]          wr_ctr;

    // Work out the new contents of the trained entry from the resolved outcome.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[upd_idx];
        wr_tag    = upd_tag;
        wr_target = target_q[upd_idx];
        wr_ctr    = ctr_q[upd_idx];
        case (upd_kind_i)
            KIND_COND: begin
                if (upd_hit) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    if (upd_taken_i == TAKEN) begin
                        wr_ctr    = sat_inc(ctr_q[upd_idx]);
                        wr_target = upd_target_i;
                    end else begin
                        wr_ctr = sat_dec(ctr_q[upd_idx]);
                    end
                end else if (upd_taken_i == TAKEN) begin
                    // Allocate weakly taken, evicting whatever was there.
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_target = upd_target_i;
                    wr_ctr    = 2'b10;
                end
            end
            KIND_JALR: begin
                // Indirect jumps are always taken; direction input is ignored.
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_target = upd_target_i;
                wr_ctr    = 2'b11;
            end
            KIND_NONE: begin
                // A non-branch that aliases onto an entry evicts it.
                if (upd_hit) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b0;
                end
            end
            default: begin
                // JAL is redirected by the front end; table untouched.
            end
        endcase
    end

    // Valid bits: cleared by reset, otherwise written by training.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= '0;
        end else if (train_en && wr_en) begin
            valid_q[upd_idx] <= wr_valid;
        end
    end

    // Entry payload: no reset needed since valid gates every read.
    always_ff @(posedge clk_i) begin
        if (train_en && wr_en) begin
            tag_q[upd_idx]    <= wr_tag;
            target_q[upd_idx] <= wr_target;
            ctr_q[upd_idx]    <= wr_ctr;
        end
    end

    // Count mispredictions reported on unstalled resolutions; wraps naturally.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mispred_cnt_o <= '0;
        end else if (train_en && upd_mispred_i) begin
            mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_branch_predictor;

    localparam int N    = 64;
    localparam int TAGN = 1024;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] fetch_pc_i;
    logic [33:0] bpred_o;
    logic        upd_valid_i;
    logic        stall_i;
    logic [31:0] upd_pc_i;
    logic [1:0]  upd_kind_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispred_i;
    logic [31:0] mispred_cnt_o;

    branch_predictor #(.NUM_ENTRIES(N), .TAG_BITS(10), .PC_WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .fetch_pc_i    (fetch_pc_i),
        .bpred_o       (bpred_o),
        .upd_valid_i   (upd_valid_i),
        .stall_i       (stall_i),
        .upd_pc_i      (upd_pc_i),
        .upd_kind_i    (upd_kind_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_mispred_i (upd_mispred_i),
        .mispred_cnt_o (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one record per BTB slot, counter as a plain integer.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(input bit isb, input bit dec, input logic [31:0] addr);
        return {isb, dec, addr};
    endfunction

    function automatic logic [33:0] m_lookup(input logic [31:0] pc);
        int unsigned idx = (pc / 4) % N;
        int unsigned tg  = (pc / (4 * N)) % TAGN;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            if (m_ctr[idx] >= 2) return mk(1'b1, 1'b1, m_tgt[idx]);
            return mk(1'b1, 1'b0, pc + 32'd4);
        end
        return mk(1'b0, 1'b0, pc + 32'd4);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_cnt = 32'd0;
    endtask

    task automatic m_train(input logic [31:0] pc, input logic [1:0] kind, input bit tk,
                           input logic [31:0] tgt, input bit mp);
        int unsigned idx = (pc / 4) % N;
        int unsigned tg  = (pc / (4 * N)) % TAGN;
        bit hit = m_valid[idx] && m_tag[idx] == tg;
        if (mp) m_cnt = m_cnt + 32'd1;
        case (kind)
            2'd1: begin
                if (hit) begin
                    if (tk) begin
                        m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                        m_tgt[idx] = tgt;
                    end else begin
                        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
                    end
                end else if (tk) begin
                    m_valid[idx] = 1'b1; m_tag[idx] = tg; m_tgt[idx] = tgt; m_ctr[idx] = 2;
                end
            end
            2'd2: begin
                m_valid[idx] = 1'b1; m_tag[idx] = tg; m_tgt[idx] = tgt; m_ctr[idx] = 3;
            end
            2'd0: if (hit) m_valid[idx] = 1'b0;
            default: ;
        endcase
    endtask

    // One clock cycle: drive, check lookup/counter before the edge, then train model.
    // Called at posedge+1.
    task automatic cycle(input logic [31:0] fpc, input bit uv, input bit st,
                         input logic [31:0] upc, input logic [1:0] kind, input bit tk,
                         input logic [31:0] tgt, input bit mp,
                         input bit use_exp, input logic [33:0] exp_bp);
        fetch_pc_i = fpc; upd_valid_i = uv; stall_i = st; upd_pc_i = upc;
        upd_kind_i = kind; upd_taken_i = tk; upd_target_i = tgt; upd_mispred_i = mp;
        @(negedge clk_i);
        check_val("bpred_model", 64'(bpred_o), 64'(m_lookup(fpc)));
        check_val("cnt_model", 64'(mispred_cnt_o), 64'(m_cnt));
        if (use_exp) check_val("bpred_same_cycle", 64'(bpred_o), 64'(exp_bp));
        @(posedge clk_i);
        if (uv && !st) m_train(upc, kind, tk, tgt, mp);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic [1:0] kind, input bit tk,
                         input logic [31:0] tgt, input bit mp);
        cycle(pc, 1'b1, 1'b0, pc, kind, tk, tgt, mp, 1'b0, '0);
    endtask

    // Pure lookup cycle with an explicitly stated expectation.
    task automatic look(input string tag, input logic [31:0] pc, input logic [33:0] exp);
        fetch_pc_i = pc; upd_valid_i = 1'b0; stall_i = 1'b0; upd_mispred_i = 1'b0;
        @(negedge clk_i);
        check_val(tag, 64'(bpred_o), 64'(exp));
        @(posedge clk_i);
        #1;
    endtask

    logic [31:0] pool [8];

    initial begin
        rstn_i = 1'b0; fetch_pc_i = 32'h1000; upd_valid_i = 1'b0; stall_i = 1'b0;
        upd_pc_i = '0; upd_kind_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
        upd_mispred_i = 1'b0;
        m_clear();
        #12;
        check_val("reset_cnt", 64'(mispred_cnt_o), 64'd0);
        check_val("reset_lookup", 64'(bpred_o), 64'(mk(0, 0, 32'h1004)));
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        look("miss_after_reset", 32'h1000, mk(0, 0, 32'h1004));

        // Allocation and hysteresis on a conditional branch.
        cycle(32'h1000, 1, 0, 32'h1000, 2'd1, 1, 32'h2000, 0, 1, mk(0, 0, 32'h1004));
        look("alloc_taken", 32'h1000, mk(1, 1, 32'h2000));
        train(32'h1000, 2'd1, 0, 32'h0, 0);
        look("weak_not_taken", 32'h1000, mk(1, 0, 32'h1004));
        train(32'h1000, 2'd1, 1, 32'h2000, 0);
        train(32'h1000, 2'd1, 1, 32'h2000, 0);
        train(32'h1000, 2'd1, 1, 32'h2000, 0);
        look("strong_taken", 32'h1000, mk(1, 1, 32'h2000));
        train(32'h1000, 2'd1, 0, 32'h0, 0);
        look("sat_hysteresis", 32'h1000, mk(1, 1, 32'h2000));
        train(32'h1000, 2'd1, 0, 32'h0, 0);
        look("sat_then_two_nt", 32'h1000, mk(1, 0, 32'h1004));

        // Aliasing: non-branch evicts, different tag replaces victim.
        train(32'h1000, 2'd1, 1, 32'h2000, 0);
        look("realloc", 32'h1000, mk(1, 1, 32'h2000));
        train(32'h1000, 2'd0, 0, 32'h0, 0);
        look("nonbranch_evict", 32'h1000, mk(0, 0, 32'h1004));
        train(32'h1000, 2'd1, 1, 32'h2000, 0);
        train(32'h1100, 2'd1, 1, 32'h5000, 0);
        look("victim_miss", 32'h1000, mk(0, 0, 32'h1004));
        look("victim_new", 32'h1100, mk(1, 1, 32'h5000));
        train(32'h1100, 2'd3, 1, 32'h9000, 0);
        look("jal_no_change", 32'h1100, mk(1, 1, 32'h5000));
        train(32'h1200, 2'd1, 0, 32'h7000, 0);
        look("cond_nt_miss_noalloc", 32'h1200, mk(0, 0, 32'h1204));

        // Stall blocks both table and counter.
        cycle(32'h1800, 1, 1, 32'h1800, 2'd1, 1, 32'h6000, 1, 0, '0);
        check_val("stall_cnt", 64'(mispred_cnt_o), 64'd0);
        look("stall_table", 32'h1800, mk(0, 0, 32'h1804));
        cycle(32'h1800, 1, 0, 32'h1800, 2'd1, 1, 32'h6000, 1, 0, '0);
        check_val("unstall_cnt", 64'(mispred_cnt_o), 64'd1);
        look("unstall_table", 32'h1800, mk(1, 1, 32'h6000));

        // JALR ignores direction; same-cycle lookup sees the old entry.
        cycle(32'h3000, 1, 0, 32'h3000, 2'd2, 0, 32'h4444, 1, 1, mk(0, 0, 32'h3004));
        look("jalr_taken", 32'h3000, mk(1, 1, 32'h4444));
        look("pc_wrap", 32'hFFFF_FFFC, mk(0, 0, 32'h0000_0000));

        // Asynchronous reset while a training write is pending.
        fetch_pc_i = 32'h3000; upd_valid_i = 1'b1; stall_i = 1'b0; upd_pc_i = 32'h3800;
        upd_kind_i = 2'd1; upd_taken_i = 1'b1; upd_target_i = 32'h8000; upd_mispred_i = 1'b1;
        #2 rstn_i = 1'b0;
        #1;
        check_val("async_rst_lookup", 64'(bpred_o), 64'(mk(0, 0, 32'h3004)));
        check_val("async_rst_cnt", 64'(mispred_cnt_o), 64'd0);
        @(posedge clk_i); #1;
        m_clear();
        upd_valid_i = 1'b0; upd_mispred_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        look("post_rst_3000", 32'h3000, mk(0, 0, 32'h3004));
        look("post_rst_3800", 32'h3800, mk(0, 0, 32'h3804));
        check_val("post_rst_cnt", 64'(mispred_cnt_o), 64'd0);

        // Randomized traffic over a small PC pool so entries collide and hit.
        for (int i = 0; i < 8; i++)
            pool[i] = 32'h1000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 2)) * 32'h100;
        for (int i = 0; i < 400; i++) begin
            cycle(pool[$urandom_range(0, 7)],
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0),
                  pool[$urandom_range(0, 7)],
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)),
                  1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
